// File: rtl/switch_debounce_pkg.sv
// Shared constants for the DIP-switch front end.
// The same values are used by the `switch` bus-read block and the top-level bridge.
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH            = 32;
  localparam int unsigned SW_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned SW_CNT_W            = 16;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-bank interface between the pads/CPU side and the debounce stage.
//   SW_I    raw asynchronous switch pads
//   ACK_I   single-cycle pulse clearing the change mask and interrupt
//   SW_O    debounced switch value
//   VALID_O SW_O holds a committed value
//   CHG_O   sticky mask of bits that changed since the last ACK_I
//   IRQ_O   sticky interrupt, high while a change is pending
// master: pad/CPU side; slave: the debounce block.
interface switch_debounce_if
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
) ();

  logic [WIDTH-1:0] SW_I;
  logic             ACK_I;
  logic [WIDTH-1:0] SW_O;
  logic             VALID_O;
  logic [WIDTH-1:0] CHG_O;
  logic             IRQ_O;

  modport master (
    output SW_I,
    output ACK_I,
    input  SW_O,
    input  VALID_O,
    input  CHG_O,
    input  IRQ_O
  );

  modport slave (
    input  SW_I,
    input  ACK_I,
    output SW_O,
    output VALID_O,
    output CHG_O,
    output IRQ_O
  );

endinterface

// File: rtl/sw_sync2.sv
// Two-flop synchroniser, one pair of flops per bit, synchronous active-high reset.
//   clk  system clock
//   rst  synchronous active-high reset (clears both stages)
//   d    asynchronous input vector
//   q    synchronised output vector (two clock delay)
module sw_sync2
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// DIP-switch conditioning stage: synchronises the raw pads, debounces them as
// one vector, and tracks which bits changed with a sticky interrupt.
//   CLK_I  system clock (single domain)
//   RST_I  synchronous active-high reset
//   bus    slave side of switch_debounce_if (SW_I/ACK_I in; SW_O, VALID_O,
//          CHG_O, IRQ_O out, all registered)
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = SW_CNT_W
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  switch_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sw_q;
  logic             valid_q;
  logic [WIDTH-1:0] chg_q;
  logic             irq_q;
  logic             commit_c;
  logic [WIDTH-1:0] diff_c;

  sw_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (CLK_I),
    .rst (RST_I),
    .d   (bus.SW_I),
    .q   (sync)
  );

  // Commit once the candidate has been stable long enough and differs from
  // what is already published (or nothing has been published since reset).
  always_comb begin
    diff_c   = cand ^ sw_q;
    commit_c = (cnt == CNT_MAX) && (sync == cand) && ((cand != sw_q) || !valid_q);
  end

  // Stability counter: any movement of the synchronised vector restarts it;
  // it saturates at CNT_MAX instead of wrapping.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync != cand) begin
      cand <= sync;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Published value and change tracking. The first commit after reset only
  // establishes a baseline; later commits accumulate changed bits. An ACK in
  // the same cycle as a commit drops the old bits but keeps the new change.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sw_q    <= '0;
      valid_q <= 1'b0;
      chg_q   <= '0;
      irq_q   <= 1'b0;
    end else if (commit_c) begin
      sw_q    <= cand;
      valid_q <= 1'b1;
      if (valid_q) begin
        chg_q <= (bus.ACK_I ? '0 : chg_q) | diff_c;
        irq_q <= 1'b1;
      end
    end else if (bus.ACK_I) begin
      chg_q <= '0;
      irq_q <= 1'b0;
    end
  end

  assign bus.SW_O    = sw_q;
  assign bus.VALID_O = valid_q;
  assign bus.CHG_O   = chg_q;
  assign bus.IRQ_O   = irq_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with a short debounce window.
// A reference model tracks the synchronised history and commits when the last
// DEBOUNCE_CYCLES+1 synchronised samples agree; outputs are compared every cycle.
module tb_switch_debounce;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(W)) bus ();

  switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_sw, m_chg, m_s1;
  logic         m_valid, m_irq;
  logic [W-1:0] hist[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied before it.
  task automatic model_edge(input logic r, input logic [W-1:0] sw, input logic ack);
    logic         stable;
    logic [W-1:0] nv;
    if (r) begin
      m_s1    = '0;
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_sw    = '0;
      m_valid = 1'b0;
      m_chg   = '0;
      m_irq   = 1'b0;
    end else begin
      nv     = hist[hist.size()-1];
      stable = (hist.size() >= int'(D) + 1);
      if (stable)
        for (int i = 0; i < int'(D) + 1; i++)
          if (hist[hist.size()-1-i] != nv) stable = 1'b0;
      if (stable && (nv != m_sw || !m_valid)) begin
        if (m_valid) begin
          m_chg = (ack ? '0 : m_chg) | (nv ^ m_sw);
          m_irq = 1'b1;
        end
        m_sw    = nv;
        m_valid = 1'b1;
      end else if (ack) begin
        m_chg = '0;
        m_irq = 1'b0;
      end
      hist.push_back(m_s1);
      m_s1 = sw;
      if (hist.size() > int'(D) + 1) void'(hist.pop_front());
    end
  endtask

  // Apply inputs, clock once, then compare all outputs with the model.
  task automatic step(input logic r, input logic [W-1:0] sw, input logic ack);
    rst       = r;
    bus.SW_I  = sw;
    bus.ACK_I = ack;
    @(posedge clk);
    model_edge(r, sw, ack);
    #1;
    check_eq("sw_o",    bus.SW_O,         m_sw);
    check_eq("valid_o", W'(bus.VALID_O),  W'(m_valid));
    check_eq("chg_o",   bus.CHG_O,        m_chg);
    check_eq("irq_o",   W'(bus.IRQ_O),    W'(m_irq));
  endtask

  task automatic hold(input logic [W-1:0] sw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, sw, 1'b0);
  endtask

  logic [W-1:0] cur;
  int           len;

  initial begin
    rst       = 1'b1;
    bus.SW_I  = '0;
    bus.ACK_I = 1'b0;

    // Reset, then first commit at edge 6 with no interrupt
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_00A5, 1'b0);
    check_eq("rst_sw",    bus.SW_O,        '0);
    check_eq("rst_valid", W'(bus.VALID_O), '0);
    for (int i = 0; i <= 8; i++) begin
      step(1'b0, 32'h0000_00A5, 1'b0);
      if (i == 5) check_eq("pre_commit_valid", W'(bus.VALID_O), '0);
      if (i == 6) begin
        check_eq("first_commit_sw",    bus.SW_O,        32'h0000_00A5);
        check_eq("first_commit_valid", W'(bus.VALID_O), 32'h1);
        check_eq("first_commit_irq",   W'(bus.IRQ_O),   '0);
        check_eq("first_commit_chg",   bus.CHG_O,       '0);
      end
    end

    // Clean change of bit 0
    for (int i = 0; i <= 8; i++) begin
      step(1'b0, 32'h0000_00A4, 1'b0);
      if (i == 5) check_eq("clean_pre_sw", bus.SW_O, 32'h0000_00A5);
      if (i == 6) begin
        check_eq("clean_sw",  bus.SW_O,      32'h0000_00A4);
        check_eq("clean_chg", bus.CHG_O,     32'h0000_0001);
        check_eq("clean_irq", W'(bus.IRQ_O), 32'h1);
      end
    end

    // Glitch on bit 7 shorter than the debounce window
    hold(32'h0000_0024, 3);
    hold(32'h0000_00A4, 10);
    check_eq("glitch_sw",  bus.SW_O,      32'h0000_00A4);
    check_eq("glitch_chg", bus.CHG_O,     32'h0000_0001);
    check_eq("glitch_irq", W'(bus.IRQ_O), 32'h1);

    // Ack, then accumulate bit 0 and bit 31
    step(1'b0, 32'h0000_00A4, 1'b1);
    check_eq("ack1_chg", bus.CHG_O,     '0);
    check_eq("ack1_irq", W'(bus.IRQ_O), '0);
    hold(32'h0000_00A5, 9);
    hold(32'h8000_00A5, 9);
    check_eq("accum_chg", bus.CHG_O,     32'h8000_0001);
    check_eq("accum_irq", W'(bus.IRQ_O), 32'h1);
    step(1'b0, 32'h8000_00A5, 1'b1);
    check_eq("ack2_chg", bus.CHG_O,     '0);
    check_eq("ack2_irq", W'(bus.IRQ_O), '0);

    // Ack collides with the commit edge of a bit-4 change
    hold(32'h8000_00A4, 9);
    check_eq("coll_pre_chg", bus.CHG_O, 32'h0000_0001);
    for (int i = 0; i <= 8; i++) begin
      step(1'b0, 32'h8000_00B4, i == 6);
      if (i == 6) begin
        check_eq("coll_chg", bus.CHG_O,     32'h0000_0010);
        check_eq("coll_irq", W'(bus.IRQ_O), 32'h1);
      end
    end

    // Reset two cycles before a pending commit; next commit is a first commit
    hold(32'h0000_0F0F, 4);
    step(1'b1, 32'h0000_0F0F, 1'b0);
    check_eq("midrst_sw",    bus.SW_O,        '0);
    check_eq("midrst_valid", W'(bus.VALID_O), '0);
    check_eq("midrst_chg",   bus.CHG_O,       '0);
    check_eq("midrst_irq",   W'(bus.IRQ_O),   '0);
    hold(32'h0000_0F0F, 10);
    check_eq("post_rst_sw",    bus.SW_O,        32'h0000_0F0F);
    check_eq("post_rst_valid", W'(bus.VALID_O), 32'h1);
    check_eq("post_rst_irq",   W'(bus.IRQ_O),   '0);

    // Randomised hold lengths around the debounce window, random acks, rare resets
    cur = 32'h0000_0F0F;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       cur = cur ^ (W'(1) << $urandom_range(0, W-1));
        1:       cur = W'($urandom);
        2:       cur = cur ^ (W'(3) << $urandom_range(0, W-2));
        default: ;
      endcase
      len = int'($urandom_range(1, 2*D + 3));
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 299) == 0, cur, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
